btn_conditioner: RTL and testbench

Conditions the three raw front-panel push buttons (set, increment, done) before they reach the watch time-setting logic. Each raw input goes through three steps:
- a 2-flop synchroniser into the 1 kHz clock domain;
- a debounce filter (stable-count);
- a press-edge detector that emits exactly one single-cycle pulse per press.
Outputs connect directly to the watch block's btn_set / btn_inc / btn_done inputs.

---
 rtl/btn_pkg.sv | 14 +
 rtl/btn_conditioner_debounce.sv | 60 ++++++
 rtl/btn_conditioner.sv | 94 +++++++++
 tb/tb_btn_conditioner.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared constants for the front-panel button conditioner.
package btn_pkg;

    localparam int unsigned DEBOUNCE_CNT_DEF  = 20;
    localparam int unsigned REPEAT_DELAY_DEF  = 500;
    localparam int unsigned REPEAT_PERIOD_DEF = 200;

    localparam int unsigned BTN_SET  = 0;
    localparam int unsigned BTN_INC  = 1;
    localparam int unsigned BTN_DONE = 2;

    localparam int unsigned BTN_NUM  = 3;

endpackage

// File: rtl/btn_conditioner_debounce.sv
// One button channel: 2-flop synchroniser, stable-count debounce, press-edge pulse.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CNT = DEBOUNCE_CNT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          stable_q, stable_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count consecutive disagreeing samples; any agreeing sample restarts the count.
    always_comb begin
        s1_d     = raw;
        s2_d     = s1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        press_d  = 1'b0;
        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = s2_q;
            cnt_d    = '0;
            press_d  = s2_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign level = stable_q;
    assign press = press_q;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions the set/inc/done push buttons into clean one-cycle press pulses.
// Define BTN_AUTOREPEAT_EN to add hold-to-repeat pulses on the inc button.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CNT  = DEBOUNCE_CNT_DEF
`ifdef BTN_AUTOREPEAT_EN
   ,parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_set_raw,
    input  logic               btn_inc_raw,
    input  logic               btn_done_raw,
    output logic               btn_set,
    output logic               btn_inc,
    output logic               btn_done,
    output logic [BTN_NUM-1:0] btn_level
);

    logic [BTN_NUM-1:0] raw;
    logic [BTN_NUM-1:0] level;
    logic [BTN_NUM-1:0] press;

    assign raw[BTN_SET]  = btn_set_raw;
    assign raw[BTN_INC]  = btn_inc_raw;
    assign raw[BTN_DONE] = btn_done_raw;

    for (genvar i = 0; i < BTN_NUM; i++) begin : g_chan
        btn_debounce #(
            .DEBOUNCE_CNT (DEBOUNCE_CNT)
        ) u_deb (
            .clk   (clk),
            .rst   (rst),
            .raw   (raw[i]),
            .level (level[i]),
            .press (press[i])
        );
    end

    assign btn_set   = press[BTN_SET];
    assign btn_done  = press[BTN_DONE];
    assign btn_level = level;

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW      = $clog2(RPT_MAX + 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic          rpt_armed_q, rpt_armed_d;
    logic          rpt_pulse_q, rpt_pulse_d;

    // Initial delay phase, then periodic phase; counter never exceeds its terminal value.
    always_comb begin
        rpt_cnt_d   = rpt_cnt_q;
        rpt_armed_d = rpt_armed_q;
        rpt_pulse_d = 1'b0;
        if (!level[BTN_INC]) begin
            rpt_cnt_d   = '0;
            rpt_armed_d = 1'b0;
        end else if (!rpt_armed_q && (rpt_cnt_q == DELAY_LAST)) begin
            rpt_cnt_d   = '0;
            rpt_armed_d = 1'b1;
            rpt_pulse_d = 1'b1;
        end else if (rpt_armed_q && (rpt_cnt_q == PERIOD_LAST)) begin
            rpt_cnt_d   = '0;
            rpt_pulse_d = 1'b1;
        end else begin
            rpt_cnt_d = rpt_cnt_q + RW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_cnt_q   <= '0;
            rpt_armed_q <= 1'b0;
            rpt_pulse_q <= 1'b0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_armed_q <= rpt_armed_d;
            rpt_pulse_q <= rpt_pulse_d;
        end
    end

    assign btn_inc = press[BTN_INC] | rpt_pulse_q;
`else
    assign btn_inc = press[BTN_INC];
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: expected pulse cycles queued at stimulus time.
module tb_btn_conditioner;
    import btn_pkg::*;

    localparam int DC = int'(DEBOUNCE_CNT_DEF);
    localparam int RD = int'(REPEAT_DELAY_DEF);
    localparam int RP = int'(REPEAT_PERIOD_DEF);

    typedef struct {
        int cyc;
        int mask;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_set_raw, btn_inc_raw, btn_done_raw;
    logic       btn_set, btn_inc, btn_done;
    logic [2:0] btn_level;
    logic [2:0] mon_p;

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    int   k, f, m;

    btn_conditioner dut (
        .clk          (clk),
        .rst          (rst),
        .btn_set_raw  (btn_set_raw),
        .btn_inc_raw  (btn_inc_raw),
        .btn_done_raw (btn_done_raw),
        .btn_set      (btn_set),
        .btn_inc      (btn_inc),
        .btn_done     (btn_done),
        .btn_level    (btn_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int c, input int msk);
        exp_t e;
        e.cyc  = c;
        e.mask = msk;
        sb.push_back(e);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Every observed pulse must match the head of the scoreboard in cycle and channel mask.
    always @(posedge clk) begin
        #1;
        mon_p = {btn_done, btn_inc, btn_set};
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            chk("missed_pulse", 0, sb[0].mask);
            void'(sb.pop_front());
        end
        if (mon_p != 3'b000) begin
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                chk("pulse", int'(mon_p), sb[0].mask);
                void'(sb.pop_front());
            end else begin
                chk("spurious_pulse", int'(mon_p), 0);
            end
        end
    end

    initial begin
        rst          = 1'b1;
        btn_set_raw  = 1'b0;
        btn_inc_raw  = 1'b0;
        btn_done_raw = 1'b0;
        wait_n(3);
        chk("reset_state", int'({btn_level, btn_done, btn_inc, btn_set}), 0);
        rst = 1'b0;
        wait_n(5);

        // clean set press held 100 cycles
        k = cyc;
        btn_set_raw = 1'b1;
        push(k + DC + 2, 3'b001);
        wait_n(DC + 1);
        chk("set_level_before", int'(btn_level[BTN_SET]), 0);
        wait_n(1);
        chk("set_level_on", int'(btn_level[BTN_SET]), 1);
        wait_n(100 - (DC + 2));
        btn_set_raw = 1'b0;
        wait_n(DC + 1);
        chk("set_level_hold", int'(btn_level[BTN_SET]), 1);
        wait_n(1);
        chk("set_level_off", int'(btn_level[BTN_SET]), 0);
        wait_n(10);

        // bouncing inc press
        btn_inc_raw = 1'b1; wait_n(5);
        btn_inc_raw = 1'b0; wait_n(3);
        btn_inc_raw = 1'b1; wait_n(7);
        btn_inc_raw = 1'b0; wait_n(2);
        chk("inc_level_bounce", int'(btn_level[BTN_INC]), 0);
        f = cyc;
        btn_inc_raw = 1'b1;
        push(f + DC + 2, 3'b010);
        wait_n(60);
        chk("inc_level_held", int'(btn_level[BTN_INC]), 1);
        btn_inc_raw = 1'b0;
        wait_n(40);

        // simultaneous set + done
        k = cyc;
        btn_set_raw  = 1'b1;
        btn_done_raw = 1'b1;
        push(k + DC + 2, 3'b101);
        wait_n(40);
        chk("set_done_level", int'(btn_level), 3'b101);
        btn_set_raw  = 1'b0;
        btn_done_raw = 1'b0;
        wait_n(40);

        // inc held 1000 cycles (auto-repeat dependent)
        f = cyc;
        btn_inc_raw = 1'b1;
        push(f + DC + 2, 3'b010);
`ifdef BTN_AUTOREPEAT_EN
        push(f + DC + 2 + RD, 3'b010);
        push(f + DC + 2 + RD + RP, 3'b010);
        push(f + DC + 2 + RD + 2 * RP, 3'b010);
`endif
        wait_n(1000);
        btn_inc_raw = 1'b0;
        wait_n(300);
        chk("inc_level_released", int'(btn_level[BTN_INC]), 0);

        // reset mid-press with all buttons held
        k = cyc;
        btn_set_raw  = 1'b1;
        btn_inc_raw  = 1'b1;
        btn_done_raw = 1'b1;
        push(k + DC + 2, 3'b111);
        wait_n(30);
        chk("all_level_pre_rst", int'(btn_level), 3'b111);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async", int'({btn_level, btn_done, btn_inc, btn_set}), 0);
        wait_n(3);
        rst = 1'b0;
        m = cyc;
        push(m + DC + 2, 3'b111);
        wait_n(DC + 1);
        chk("post_rst_level_before", int'(btn_level), 0);
        wait_n(1);
        chk("post_rst_level_on", int'(btn_level), 3'b111);
        wait_n(10);
        btn_set_raw  = 1'b0;
        btn_inc_raw  = 1'b0;
        btn_done_raw = 1'b0;
        wait_n(40);
        chk("final_level", int'(btn_level), 0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
